// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the Thumb-subset core.
// Classifies IR[15:7] and drives the fetch, datapath and data-memory enables.
module core_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      i_ir,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  input  logic             i_cond_pass,
  output logic             o_imem_req,
  output logic             o_ir_en,
  output logic             o_pc_inc,
  output logic             o_pc_load,
  output logic             o_stall,
  output logic             o_alu_en,
  output logic             o_flags_we,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic             o_rf_we,
  output logic             o_undef,
  output logic             o_err,
  output logic             o_done,
  output logic [CNT_W-1:0] o_retired,
  output logic [2:0]       o_state
);

  localparam int unsigned TO_W = 8;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_ALU   = 3'd1,
    C_LD    = 3'd2,
    C_ST    = 3'd3,
    C_BR    = 3'd4,
    C_BC    = 3'd5,
    C_CMP   = 3'd6,
    C_UNDEF = 3'd7
  } cls_t;

  state_t          state, state_nxt;
  cls_t            cls, cls_nxt, dec_cls;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic            err_set;
  logic            unused_ir;

  // Opcode classes share their encodings with the instruction decoder
  function automatic cls_t classify(input logic [8:0] op);
    cls_t c;
    c = C_UNDEF;
    if (op[8:2] == 7'b0001110 || op[8:4] == 5'b10101 || op == 9'b101100001 ||
        op[8:4] == 5'b00100 || op[8:1] == 8'b01000110)
      c = C_ALU;
    else if (op[8:4] == 5'b01101 || op[8:4] == 5'b01001)
      c = C_LD;
    else if (op[8:4] == 5'b01100)
      c = C_ST;
    else if (op[8:4] == 5'b11100)
      c = C_BR;
    else if (op[8:5] == 4'b1101)
      c = C_BC;
    else if (op[8:4] == 5'b00101)
      c = C_CMP;
    return c;
  endfunction

  assign dec_cls   = classify(i_ir[15:7]);
  assign unused_ir = ^i_ir[6:0];
  assign o_state   = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_FETCH;
      cls       <= C_NONE;
      cnt       <= '0;
      o_err     <= 1'b0;
      o_retired <= '0;
    end else begin
      state <= state_nxt;
      cls   <= cls_nxt;
      cnt   <= cnt_nxt;
      if (err_set) o_err <= 1'b1;
      if (o_done)  o_retired <= o_retired + CNT_W'(1);
    end
  end

  // Next state and phase enables; everything idles with stall high in reset
  always_comb begin
    state_nxt  = state;
    cls_nxt    = cls;
    cnt_nxt    = cnt;
    err_set    = 1'b0;
    o_imem_req = 1'b0;
    o_ir_en    = 1'b0;
    o_pc_inc   = 1'b0;
    o_pc_load  = 1'b0;
    o_stall    = 1'b1;
    o_alu_en   = 1'b0;
    o_flags_we = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_rf_we    = 1'b0;
    o_undef    = 1'b0;
    o_done     = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          o_imem_req = 1'b1;
          if (i_imem_ready) begin
            o_ir_en   = 1'b1;
            o_pc_inc  = 1'b1;
            state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          o_stall = 1'b0;
          cls_nxt = dec_cls;
          if (dec_cls == C_UNDEF) begin
            o_undef   = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          o_alu_en = 1'b1;
          case (cls)
            C_BR: begin
              o_pc_load = 1'b1;
              o_done    = 1'b1;
              state_nxt = S_FETCH;
            end
            C_BC: begin
              o_pc_load = i_cond_pass;
              o_done    = 1'b1;
              state_nxt = S_FETCH;
            end
            C_CMP: begin
              o_flags_we = 1'b1;
              o_done     = 1'b1;
              state_nxt  = S_FETCH;
            end
            C_LD, C_ST: begin
              cnt_nxt   = '0;
              state_nxt = S_MEM;
            end
            C_ALU:   state_nxt = S_WB;
            default: state_nxt = S_FETCH;
          endcase
        end
        S_MEM: begin
          o_dmem_req = 1'b1;
          o_dmem_we  = (cls == C_ST);
          // A ready on the final allowed cycle still completes normally
          if (i_dmem_ready) begin
            if (cls == C_ST) begin
              o_done    = 1'b1;
              state_nxt = S_FETCH;
            end else begin
              state_nxt = S_WB;
            end
          end else if (cnt == TO_W'(MEM_TIMEOUT - 1)) begin
            err_set   = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            cnt_nxt = cnt + TO_W'(1);
          end
        end
        S_WB: begin
          o_rf_we   = 1'b1;
          o_done    = 1'b1;
          state_nxt = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Table-driven bench for core_seq_ctrl: one record per cycle with inputs and
// expected state, enable vector and retired count.
module tb_core_seq_ctrl;

  localparam int unsigned CNT_W = 4;

  // Enable vector bit order, MSB first:
  // imem_req ir_en pc_inc pc_load stall alu_en flags_we dmem_req dmem_we rf_we undef err done
  localparam logic [12:0] O_RST = 13'h0100;
  localparam logic [12:0] O_FR  = 13'h1D00;
  localparam logic [12:0] O_FW  = 13'h1100;
  localparam logic [12:0] O_DEC = 13'h0000;
  localparam logic [12:0] O_UND = 13'h0004;
  localparam logic [12:0] O_EX  = 13'h0180;
  localparam logic [12:0] O_EXB = 13'h0381;
  localparam logic [12:0] O_EXN = 13'h0181;
  localparam logic [12:0] O_CMP = 13'h01C1;
  localparam logic [12:0] O_MLD = 13'h0120;
  localparam logic [12:0] O_MST = 13'h0130;
  localparam logic [12:0] O_MSD = 13'h0131;
  localparam logic [12:0] O_WB  = 13'h0109;
  localparam logic [12:0] O_ERR = 13'h0002;

  localparam logic [15:0] I_ADD = 16'h1C48;
  localparam logic [15:0] I_LDR = 16'h6808;
  localparam logic [15:0] I_STR = 16'h6008;
  localparam logic [15:0] I_BC  = 16'hD0FE;
  localparam logic [15:0] I_BR  = 16'hE000;
  localparam logic [15:0] I_CMP = 16'h2805;
  localparam logic [15:0] I_UND = 16'hFFFF;

  typedef struct {
    logic             rst;
    logic [15:0]      ir;
    logic             imr;
    logic             dmr;
    logic             cp;
    logic [2:0]       st;
    logic [12:0]      outs;
    logic [CNT_W-1:0] ret;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [15:0]      i_ir;
  logic             i_imem_ready, i_dmem_ready, i_cond_pass;
  logic             o_imem_req, o_ir_en, o_pc_inc, o_pc_load, o_stall, o_alu_en;
  logic             o_flags_we, o_dmem_req, o_dmem_we, o_rf_we, o_undef, o_err, o_done;
  logic [CNT_W-1:0] o_retired;
  logic [2:0]       o_state;
  logic [12:0]      act;

  vec_t vq[$];
  int   n_checks;
  int   n_fail;

  core_seq_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_ir(i_ir), .i_imem_ready(i_imem_ready),
    .i_dmem_ready(i_dmem_ready), .i_cond_pass(i_cond_pass),
    .o_imem_req(o_imem_req), .o_ir_en(o_ir_en), .o_pc_inc(o_pc_inc),
    .o_pc_load(o_pc_load), .o_stall(o_stall), .o_alu_en(o_alu_en),
    .o_flags_we(o_flags_we), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_rf_we(o_rf_we), .o_undef(o_undef), .o_err(o_err), .o_done(o_done),
    .o_retired(o_retired), .o_state(o_state)
  );

  assign act = {o_imem_req, o_ir_en, o_pc_inc, o_pc_load, o_stall, o_alu_en,
                o_flags_we, o_dmem_req, o_dmem_we, o_rf_we, o_undef, o_err, o_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic v(input logic r, input logic [15:0] ir, input logic imr,
                   input logic dmr, input logic cp, input logic [2:0] st,
                   input logic [12:0] o, input int ret);
    vec_t x;
    x.rst = r; x.ir = ir; x.imr = imr; x.dmr = dmr; x.cp = cp;
    x.st = st; x.outs = o; x.ret = CNT_W'(ret);
    vq.push_back(x);
  endtask

  // Fetch, decode and exec cycles shared by every defined instruction
  task automatic fde(input logic [15:0] ir, input logic cp, input logic [12:0] ex,
                     input logic [12:0] e, input int ret);
    v(1'b1, ir, 1'b1, 1'b0, 1'b0, 3'd0, O_FR | e, ret);
    v(1'b1, ir, 1'b1, 1'b0, 1'b0, 3'd1, O_DEC | e, ret);
    v(1'b1, ir, 1'b1, 1'b0, cp, 3'd2, ex | e, ret);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; i_ir = I_ADD; i_imem_ready = 1'b1; i_dmem_ready = 1'b0; i_cond_pass = 1'b0;

    for (int k = 0; k < 3; k++) v(1'b0, I_ADD, 1'b1, 1'b0, 1'b0, 3'd0, O_RST, 0);
    v(1'b1, I_ADD, 1'b0, 1'b0, 1'b0, 3'd0, O_FW, 0);
    // ADD: 4 cycles ending in WB
    fde(I_ADD, 1'b0, O_EX, 13'h0, 0);
    v(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, 3'd4, O_WB, 0);
    // LDR with three wait cycles
    fde(I_LDR, 1'b0, O_EX, 13'h0, 1);
    for (int k = 0; k < 3; k++) v(1'b1, I_LDR, 1'b1, 1'b0, 1'b0, 3'd3, O_MLD, 1);
    v(1'b1, I_LDR, 1'b1, 1'b1, 1'b0, 3'd3, O_MLD, 1);
    v(1'b1, I_LDR, 1'b1, 1'b0, 1'b0, 3'd4, O_WB, 1);
    // Conditional branch not taken, taken; then unconditional branch
    fde(I_BC, 1'b0, O_EXN, 13'h0, 2);
    fde(I_BC, 1'b1, O_EXB, 13'h0, 3);
    fde(I_BR, 1'b0, O_EXB, 13'h0, 4);
    // Zero-wait store
    fde(I_STR, 1'b0, O_EX, 13'h0, 5);
    v(1'b1, I_STR, 1'b1, 1'b1, 1'b0, 3'd3, O_MSD, 5);
    // Load whose ready arrives on the last allowed MEM cycle
    fde(I_LDR, 1'b0, O_EX, 13'h0, 6);
    for (int k = 0; k < 15; k++) v(1'b1, I_LDR, 1'b1, 1'b0, 1'b0, 3'd3, O_MLD, 6);
    v(1'b1, I_LDR, 1'b1, 1'b1, 1'b0, 3'd3, O_MLD, 6);
    v(1'b1, I_LDR, 1'b1, 1'b0, 1'b0, 3'd4, O_WB, 6);
    // Store timeout: 16 MEM cycles, error latches, no retire
    fde(I_STR, 1'b0, O_EX, 13'h0, 7);
    for (int k = 0; k < 16; k++) v(1'b1, I_STR, 1'b1, 1'b0, 1'b0, 3'd3, O_MST, 7);
    v(1'b1, I_STR, 1'b0, 1'b0, 1'b0, 3'd0, O_FW | O_ERR, 7);
    v(1'b1, I_STR, 1'b0, 1'b0, 1'b0, 3'd0, O_FW | O_ERR, 7);
    // Error persists; reset mid-MEM drops the request at once, then clears
    fde(I_LDR, 1'b0, O_EX, O_ERR, 7);
    v(1'b1, I_LDR, 1'b1, 1'b0, 1'b0, 3'd3, O_MLD | O_ERR, 7);
    v(1'b0, I_LDR, 1'b1, 1'b0, 1'b0, 3'd3, O_RST | O_ERR, 7);
    v(1'b0, I_LDR, 1'b1, 1'b0, 1'b0, 3'd0, O_RST, 0);
    // Undefined opcode pulses undef in DECODE and retires nothing
    v(1'b1, I_UND, 1'b1, 1'b0, 1'b0, 3'd0, O_FR, 0);
    v(1'b1, I_UND, 1'b1, 1'b0, 1'b0, 3'd1, O_UND, 0);
    v(1'b1, I_UND, 1'b0, 1'b0, 1'b0, 3'd0, O_FW, 0);
    // Sixteen CMPs wrap the 4-bit retired counter back to 0
    for (int k = 0; k < 16; k++) fde(I_CMP, 1'b0, O_CMP, 13'h0, k % 16);
    v(1'b1, I_CMP, 1'b0, 1'b0, 1'b0, 3'd0, O_FW, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vq[i].rst; i_ir = vq[i].ir; i_imem_ready = vq[i].imr;
      i_dmem_ready = vq[i].dmr; i_cond_pass = vq[i].cp;
      @(negedge clk);
      n_checks++;
      if (o_state !== vq[i].st) begin
        n_fail++;
        $display("FAIL state vec %0d: got %0d expected %0d", i, o_state, vq[i].st);
      end
      n_checks++;
      if (act !== vq[i].outs) begin
        n_fail++;
        $display("FAIL enables vec %0d: got %b expected %b", i, act, vq[i].outs);
      end
      n_checks++;
      if (o_retired !== vq[i].ret) begin
        n_fail++;
        $display("FAIL retired vec %0d: got %0d expected %0d", i, o_retired, vq[i].ret);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
